data_sram_slave: RTL and testbench
==================================

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 Clock and reset SHALL be one clock `clk` and asynchronous active-low reset `resetn`.
REQ-002 Parameter RAM_AW, default 10, SHALL give log2 of the scratch RAM depth in 32-bit words.
REQ-003 Port `clk`: input, 1 bit, rising-edge clock.
REQ-004 Port `resetn`: input, 1 bit, asynchronous active-low reset.
REQ-005 Port `data_sram_en`: input, 1 bit, access request this cycle.
REQ-006 Port `data_sram_we`: input, 4 bits, byte write enables; 0 means read.
REQ-007 Port `data_sram_addr`: input, 32 bits, byte address; only [15:2] are decoded.
REQ-008 Port `data_sram_wdata`: input, 32 bits, write data.
REQ-009 Port `data_sram_rdata`: output, 32 bits, read data, valid the cycle after the read request.
REQ-010 Port `switch`: input, 8 bits, asynchronous board switches.
REQ-011 Port `led`: output, 16 bits, LED register value.
REQ-012 Port `timer_irq`: output, 1 bit, timer interrupt pending.

Function
REQ-013 The block SHALL decode the address map as follows:
- addr[15:12]=0x0: scratch RAM (2^RAM_AW words, index addr[RAM_AW+1:2]).
- 0xF000: LED (RW, bits[15:0]).
- 0xF004: SWITCH (RO, bits[7:0]).
- 0xF008: TIMER (RW).
- 0xF00C: TIMER_CMP (RW).
- 0xF010: TIMER_CTRL (bit0 enable RW; bit1 pending, write-1-to-clear).
REQ-014 Any other address SHALL read 0, and writes to it SHALL be ignored.
REQ-015 A write (en=1, we!=0) SHALL update only the bytes whose we bit is set, effective at the clock edge of the request.
REQ-016 A read (en=1, we=0) SHALL register the addressed word into `data_sram_rdata` at the request edge (1-cycle latency).
REQ-017 Cycles with en=0 or with a write SHALL leave `data_sram_rdata` unchanged.
REQ-018 A read of a location written on the previous cycle SHALL return the new value.
REQ-019 Back-to-back requests SHALL be accepted every cycle with no stall.
REQ-020 `switch` SHALL pass through a 2-flop synchronizer before being read, giving 2-cycle input latency.
REQ-021 TIMER SHALL increment by 1 each cycle while enable=1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-022 A software write to TIMER SHALL take priority over the increment in the same cycle.
REQ-023 When enable=1 and TIMER==TIMER_CMP, pending SHALL be set on the next edge.
REQ-024 A set and a write-1-to-clear of pending in the same cycle SHALL leave pending set.
REQ-025 `timer_irq` SHALL equal pending.
REQ-026 `led` SHALL equal the LED register.

Reset
REQ-027 On resetn=0, the block SHALL immediately clear rdata, LED, the synchronizer flops, TIMER, TIMER_CMP and TIMER_CTRL to 0, independent of clk.
REQ-028 Scratch RAM contents SHALL NOT be reset.
REQ-029 A request whose cycle overlaps reset assertion SHALL be discarded.
REQ-030 The first request SHALL be accepted on the first clock edge after resetn deasserts.

Configuration
REQ-031 With macro SLAVE_TIMER_EN defined, TIMER, TIMER_CMP, TIMER_CTRL and `timer_irq` SHALL be implemented as specified above.
REQ-032 Without SLAVE_TIMER_EN, addresses 0xF008-0xF010 SHALL read 0 and ignore writes, `timer_irq` SHALL be tied to 0, and no timer flops SHALL exist.

Verification
REQ-033 Scratch RAM byte writes: write 0x11223344 with we=0xF to 0x0010, then write 0xAA with we=0x1 to the same address, then read it -> rdata=0x112233AA on the cycle after the read.
REQ-034 Read after write: read 0x0010 in the cycle immediately after a write of 0xDEADBEEF -> rdata=0xDEADBEEF one cycle later.
REQ-035 LED and unmapped access: write 0xFFFF1234 to 0xF000 -> led=0x1234; a read of 0xF000 returns 0x00001234; a read of 0xF100 returns 0.
REQ-036 Switch synchronizer: set switch=0x5A, then read 0xF004 on the following cycles -> 0 for the first 2 cycles, then 0x0000005A.
REQ-037 Timer interrupt (SLAVE_TIMER_EN): set CMP=5, TIMER=0, CTRL=1 -> timer_irq rises 6 cycles after the enable write; writing 2 to CTRL clears pending.
REQ-038 Asynchronous reset: pulse resetn low mid-stream after led=0x1234 and rdata!=0 -> led=0, rdata=0 and timer_irq=0 with no clock edge required; RAM data is retained.

Source files
------------

// File: rtl/data_sram_slave.sv
// Single-cycle SRAM-style slave: scratch RAM, LED register, synchronised switches
// and an optional compare timer built only when SLAVE_TIMER_EN is defined.
module data_sram_slave #(
  parameter int unsigned RAM_AW = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
  localparam logic [13:0] LED_WA    = 14'h3C00;
  localparam logic [13:0] SW_WA     = 14'h3C01;
`ifdef SLAVE_TIMER_EN
  localparam logic [13:0] TMR_WA    = 14'h3C02;
  localparam logic [13:0] CMP_WA    = 14'h3C03;
  localparam logic [13:0] CTRL_WA   = 14'h3C04;
`endif

  logic [13:0]       word_a;
  logic              ram_sel;
  logic              wr_req;
  logic              rd_req;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       rd_word;
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       led_q, led_d;
  logic [7:0]        sync1_q, sync2_q;
  logic [31:0]       mem [RAM_DEPTH];
  logic              unused_addr;

`ifdef SLAVE_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        ten_q, ten_d;
  logic        pend_q, pend_d;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  assign word_a      = data_sram_addr[15:2];
  assign ram_sel     = (data_sram_addr[15:12] == 4'h0);
  assign ram_idx     = data_sram_addr[RAM_AW+1:2];
  assign wr_req      = data_sram_en && (data_sram_we != 4'h0);
  assign rd_req      = data_sram_en && (data_sram_we == 4'h0);
  assign unused_addr = ^{data_sram_addr[31:16], data_sram_addr[1:0]};

  // Scratch RAM has no reset; writes seen while in reset are dropped.
  always_ff @(posedge clk) begin : ram_write
    if (resetn && wr_req && ram_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) mem[ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin : read_mux
    rd_word = '0;
    if (ram_sel) begin
      rd_word = mem[ram_idx];
    end else begin
      case (word_a)
        LED_WA:  rd_word = {16'h0, led_q};
        SW_WA:   rd_word = {24'h0, sync2_q};
`ifdef SLAVE_TIMER_EN
        TMR_WA:  rd_word = timer_q;
        CMP_WA:  rd_word = cmp_q;
        CTRL_WA: rd_word = {30'h0, pend_q, ten_q};
`endif
        default: rd_word = '0;
      endcase
    end
  end

  always_comb begin : core_next
    rdata_d = rdata_q;
    led_d   = led_q;
    if (rd_req) rdata_d = rd_word;
    if (wr_req && (word_a == LED_WA)) begin
      led_d = 16'(merge_bytes({16'h0, led_q}, data_sram_wdata, data_sram_we));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin : core_regs
    if (!resetn) begin
      rdata_q <= '0;
      led_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      sync1_q <= switch;
      sync2_q <= sync1_q;
    end
  end

`ifdef SLAVE_TIMER_EN
  always_comb begin : timer_next
    timer_d = timer_q;
    cmp_d   = cmp_q;
    ten_d   = ten_q;
    pend_d  = pend_q;
    if (ten_q) timer_d = timer_q + 32'd1;
    if (wr_req && (word_a == TMR_WA)) timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_we);
    if (wr_req && (word_a == CMP_WA)) cmp_d = merge_bytes(cmp_q, data_sram_wdata, data_sram_we);
    if (wr_req && (word_a == CTRL_WA) && data_sram_we[0]) begin
      ten_d = data_sram_wdata[0];
      if (data_sram_wdata[1]) pend_d = 1'b0;
    end
    // A compare hit wins over a same-cycle clear.
    if (ten_q && (timer_q == cmp_q)) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin : timer_regs
    if (!resetn) begin
      timer_q <= '0;
      cmp_q   <= '0;
      ten_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      ten_q   <= ten_d;
      pend_q  <= pend_d;
    end
  end

  assign timer_irq = pend_q;
`else
  assign timer_irq = 1'b0;
`endif

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Scoreboard bench for data_sram_slave: a driver advances a reference model one
// clock per request and queues expected outputs; a monitor pops and compares.
module tb_data_sram_slave;

`ifdef SLAVE_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic        timer_irq;

  data_sram_slave #(.RAM_AW(10)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .timer_irq       (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [15:0] led;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_mem [1024];
  logic [31:0] m_rdata, m_timer, m_cmp;
  logic [15:0] m_led;
  logic        m_ten, m_pend;
  logic [7:0]  sw_log[$];
  logic [7:0]  sw_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [15:0] off;
    off = {a[15:2], 2'b00};
    if (off[15:12] == 4'h0) return m_mem[off[11:2]];
    case (off)
      16'hF000: return {16'h0, m_led};
      16'hF004: return {24'h0, sw_log[sw_log.size()-2]};
      16'hF008: return TMR ? m_timer : 32'h0;
      16'hF00C: return TMR ? m_cmp : 32'h0;
      16'hF010: return TMR ? {30'h0, m_pend, m_ten} : 32'h0;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_rdata = '0; m_led = '0; m_timer = '0; m_cmp = '0; m_ten = 1'b0; m_pend = 1'b0;
    sw_log.delete();
    sw_log.push_back(8'h0);
    sw_log.push_back(8'h0);
  endtask

  // Drive one request at the falling edge and advance the model over the next rising edge.
  task automatic do_cycle(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rv, nt;
    logic [15:0] off;
    logic        set_p, clr_p;
    exp_t        e;
    @(negedge clk);
    data_sram_en = en; data_sram_we = we; data_sram_addr = addr; data_sram_wdata = wd; switch = sw_val;
    off   = {addr[15:2], 2'b00};
    rv    = m_read(addr);
    set_p = TMR && m_ten && (m_timer == m_cmp);
    clr_p = 1'b0;
    nt    = m_ten ? m_timer + 32'd1 : m_timer;
    if (en && we == 4'h0) m_rdata = rv;
    if (en && we != 4'h0) begin
      if (off[15:12] == 4'h0) m_mem[off[11:2]] = merge(m_mem[off[11:2]], wd, we);
      else if (off == 16'hF000) m_led = 16'(merge({16'h0, m_led}, wd, we));
      else if (TMR && off == 16'hF008) nt = merge(m_timer, wd, we);
      else if (TMR && off == 16'hF00C) m_cmp = merge(m_cmp, wd, we);
      else if (TMR && off == 16'hF010 && we[0]) begin
        m_ten = wd[0];
        clr_p = wd[1];
      end
    end
    m_timer = TMR ? nt : 32'h0;
    m_pend  = set_p ? 1'b1 : (clr_p ? 1'b0 : m_pend);
    sw_log.push_back(sw_val);
    e.rdata = m_rdata; e.led = m_led; e.irq = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] mk(input logic [15:0] base);
    return {16'($urandom), base[15:2], 2'($urandom)};
  endfunction

  // Monitor: one expected entry per modelled clock edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_rdata", data_sram_rdata, e.rdata);
      check("sb_led", {16'h0, led}, {16'h0, e.led});
      check("sb_irq", {31'h0, timer_irq}, {31'h0, e.irq});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  we;
    logic        en;
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_we = '0; data_sram_addr = '0;
    data_sram_wdata = '0; sw_val = 8'h0; switch = 8'h0;
    m_reset();
    #1;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk);
    #3 resetn = 1'b1;

    for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'hF, 32'(i * 4), $urandom);

    // Byte-enable merge into RAM
    do_cycle(1'b1, 4'hF, 32'h0010, 32'h11223344);
    do_cycle(1'b1, 4'h1, 32'h0010, 32'h000000AA);
    do_cycle(1'b1, 4'h0, 32'h0010, 32'h0);
    after_edge();
    check("byte_merge", data_sram_rdata, 32'h112233AA);

    // Read immediately after write
    do_cycle(1'b1, 4'hF, 32'h0010, 32'hDEADBEEF);
    do_cycle(1'b1, 4'h0, 32'h0010, 32'h0);
    after_edge();
    check("raw", data_sram_rdata, 32'hDEADBEEF);

    // LED and unmapped
    do_cycle(1'b1, 4'hF, 32'h0000F000, 32'hFFFF1234);
    after_edge();
    check("led_out", {16'h0, led}, 32'h1234);
    do_cycle(1'b1, 4'h0, 32'h0000F000, 32'h0);
    after_edge();
    check("led_read", data_sram_rdata, 32'h00001234);
    do_cycle(1'b1, 4'h0, 32'h0000F100, 32'h0);
    after_edge();
    check("unmapped_read", data_sram_rdata, 32'h0);

    // Switch synchroniser latency
    sw_val = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 4'h0, 32'h0000F004, 32'h0);
      after_edge();
      check("switch_sync", data_sram_rdata, (i < 2) ? 32'h0 : 32'h5A);
    end

`ifdef SLAVE_TIMER_EN
    do_cycle(1'b1, 4'hF, 32'h0000F00C, 32'd5);
    do_cycle(1'b1, 4'hF, 32'h0000F008, 32'd0);
    do_cycle(1'b1, 4'hF, 32'h0000F010, 32'd1);
    after_edge();
    for (int i = 1; i <= 6; i++) begin
      do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
      after_edge();
      check("irq_rise", {31'h0, timer_irq}, (i == 6) ? 32'h1 : 32'h0);
    end
    do_cycle(1'b1, 4'hF, 32'h0000F010, 32'd2);
    after_edge();
    check("irq_clear", {31'h0, timer_irq}, 32'h0);
`endif

    // Asynchronous reset mid-stream
    do_cycle(1'b1, 4'h0, 32'h0010, 32'h0);
    after_edge();
    check("pre_rst_rdata", data_sram_rdata, 32'hDEADBEEF);
    check("pre_rst_led", {16'h0, led}, 32'h1234);
    resetn = 1'b0;
    #1;
    check("async_rst_rdata", data_sram_rdata, 32'h0);
    check("async_rst_led", {16'h0, led}, 32'h0);
    check("async_rst_irq", {31'h0, timer_irq}, 32'h0);
    m_reset();
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_we = 4'hF; data_sram_addr = 32'h0010; data_sram_wdata = 32'hBAD0BAD0;
    @(posedge clk);
    #3 resetn = 1'b1;
    do_cycle(1'b1, 4'h0, 32'h0010, 32'h0);
    after_edge();
    check("ram_retained", data_sram_rdata, 32'hDEADBEEF);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) sw_val = 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: a = {16'($urandom), 4'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
        3: a = mk(16'hF000);
        4: a = mk(16'hF004);
        5: begin a = mk(16'hF008); wd = 32'($urandom_range(0, 40)); end
        6: begin a = mk(16'hF00C); wd = 32'($urandom_range(0, 40)); end
        7, 8: begin a = mk(16'hF010); wd = 32'($urandom_range(0, 3)); end
        default: a = ($urandom_range(0, 1) == 0) ? mk(16'hF100) : mk(16'h1000 | 16'($urandom_range(0, 255) << 2));
      endcase
      do_cycle(en, we, a, wd);
    end

    do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    after_edge();
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
